// File: rtl/elevator_pkg.sv
// Shared constants, bit maps and types for the elevator request queue.
//   Hall map  : [5:0] up floors 1..6, [11:6] down floors 2..7
//   Car map   : [7:1] floors 1..7, [8] open, [9] close
//   reqIndex  : 0..11 hall, 12..18 car1, 19..25 car2, 26..32 car3
package elevator_pkg;

    localparam int unsigned NUM_FLOORS    = 7;
    localparam int unsigned NUM_CARS      = 3;

    localparam int unsigned HALL_W        = 12;
    localparam int unsigned CAR_BTN_W     = 9;
    // Offsets inside a car's 9-bit button group (bit 0 == floor 1)
    localparam int unsigned OPEN_OFS      = 7;
    localparam int unsigned CLOSE_OFS     = 8;
    localparam int unsigned NUM_BTNS      = HALL_W + NUM_CARS * CAR_BTN_W;

    // Request index space: hall bits then car floor bits
    localparam int unsigned REQ_HALL_BASE = 0;
    localparam int unsigned REQ_CAR1_BASE = 12;
    localparam int unsigned REQ_CAR2_BASE = 19;
    localparam int unsigned REQ_CAR3_BASE = 26;
    localparam int unsigned NUM_REQ       = HALL_W + NUM_CARS * NUM_FLOORS;
    localparam int unsigned IDX_W         = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } ann_state_e;

    // Index of the lowest set bit; 0 when none is set
    function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_edge_filter.sv
// Single-bit debounce filter with a registered press pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : raw button level
//   rise_o     : one-cycle pulse in the cycle the filtered level first reads 1
module button_edge_filter #(
    parameter int unsigned FILTER_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o
);

    localparam int unsigned HIST_W = FILTER_CYCLES - 1;

    logic [HIST_W-1:0]        hist_q;
    logic                     level_q;
    logic                     rise_q;
    logic [FILTER_CYCLES-1:0] window_c;
    logic                     all_hi_c;
    logic                     all_lo_c;

    // Current sample plus the previous FILTER_CYCLES-1 samples
    assign window_c = {hist_q, raw_i};
    assign all_hi_c = &window_c;
    assign all_lo_c = ~|window_c;

    // Level only moves on a fully agreeing window; mixed windows hold it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            hist_q <= window_c[HIST_W-1:0];
            rise_q <= all_hi_c & ~level_q;
            if (all_hi_c) begin
                level_q <= 1'b1;
            end else if (all_lo_c) begin
                level_q <= 1'b0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/elevator_request_queue.sv
// Latches hall/car floor requests from filtered buttons, pulses door
// commands, and announces each new request once over a valid/ready stream.
//   clk, reset           : clock, asynchronous active-low reset
//   newRealFloorButton   : hall button levels (12)
//   newInternalButton1-3 : car button levels [9:1]
//   serveHall, serveCar* : one-cycle clear strobes
//   pendingHall/Car*     : latched pending requests
//   doorOpen/doorClose   : one-cycle door pulses per car [3:1]
//   reqValid/reqIndex/reqReady : new-request announcement handshake
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [11:0]          newRealFloorButton,
    input  logic [9:1]           newInternalButton1,
    input  logic [9:1]           newInternalButton2,
    input  logic [9:1]           newInternalButton3,
    input  logic [11:0]          serveHall,
    input  logic [7:1]           serveCar1,
    input  logic [7:1]           serveCar2,
    input  logic [7:1]           serveCar3,
    output logic [11:0]          pendingHall,
    output logic [7:1]           pendingCar1,
    output logic [7:1]           pendingCar2,
    output logic [7:1]           pendingCar3,
    output logic [3:1]           doorOpen,
    output logic [3:1]           doorClose,
    output logic                 reqValid,
    output logic [5:0]           reqIndex,
    input  logic                 reqReady
);

    logic [NUM_BTNS-1:0] raw_c;
    logic [NUM_BTNS-1:0] rise_c;
    logic [NUM_REQ-1:0]  press_c;
    logic [NUM_REQ-1:0]  serve_c;
    logic [NUM_CARS-1:0] door_open_c;
    logic [NUM_CARS-1:0] door_close_c;

    logic [NUM_REQ-1:0]  pending_q;
    logic [NUM_REQ-1:0]  unrep_q;
    logic [NUM_REQ-1:0]  unrep_d;
    logic [NUM_REQ-1:0]  hs_mask_c;
    logic [NUM_CARS-1:0] door_open_q;
    logic [NUM_CARS-1:0] door_close_q;

    ann_state_e          state_q;
    logic                valid_q;
    logic [IDX_W-1:0]    idx_q;
    logic                hs_c;

    assign raw_c   = {newInternalButton3, newInternalButton2, newInternalButton1, newRealFloorButton};
    assign serve_c = {serveCar3, serveCar2, serveCar1, serveHall};

    // One filter per physical button bit
    for (genvar b = 0; b < int'(NUM_BTNS); b++) begin : g_btn
        button_edge_filter #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_filt (
            .clk    (clk),
            .rst_n  (reset),
            .raw_i  (raw_c[b]),
            .rise_o (rise_c[b])
        );
    end

    // Map button pulses onto request indices and door commands
    assign press_c[REQ_HALL_BASE +: HALL_W] = rise_c[HALL_W-1:0];
    for (genvar c = 0; c < int'(NUM_CARS); c++) begin : g_car
        localparam int unsigned RB = HALL_W + CAR_BTN_W * c;
        localparam int unsigned QB = REQ_CAR1_BASE + NUM_FLOORS * c;
        assign press_c[QB +: NUM_FLOORS] = rise_c[RB +: NUM_FLOORS];
        assign door_open_c[c]            = rise_c[RB + OPEN_OFS];
        assign door_close_c[c]           = rise_c[RB + CLOSE_OFS];
    end

    assign hs_c      = valid_q & reqReady;
    assign hs_mask_c = hs_c ? (NUM_REQ'(1) << idx_q) : '0;

    // New presses are unreported only if not already pending; serve wins
    assign unrep_d = ((unrep_q | (press_c & ~pending_q)) & ~serve_c) & ~hs_mask_c;

    // Request latches and door pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q    <= '0;
            unrep_q      <= '0;
            door_open_q  <= '0;
            door_close_q <= '0;
        end else begin
            pending_q    <= (pending_q | press_c) & ~serve_c;
            unrep_q      <= unrep_d;
            door_open_q  <= door_open_c;
            door_close_q <= door_close_c;
        end
    end

    // Announcer: offer lowest unreported index, hold it until accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|unrep_q) begin
                        state_q <= ST_OFFER;
                        valid_q <= 1'b1;
                        idx_q   <= lowest_index(unrep_q);
                    end
                end
                ST_OFFER: begin
                    if (reqReady) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pendingHall = pending_q[REQ_HALL_BASE +: HALL_W];
    assign pendingCar1 = pending_q[REQ_CAR1_BASE +: NUM_FLOORS];
    assign pendingCar2 = pending_q[REQ_CAR2_BASE +: NUM_FLOORS];
    assign pendingCar3 = pending_q[REQ_CAR3_BASE +: NUM_FLOORS];
    assign doorOpen    = door_open_q;
    assign doorClose   = door_close_q;
    assign reqValid    = valid_q;
    assign reqIndex    = idx_q;

endmodule
